pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage RV32 core (IF/ID/EX/MEM/WB). It consumes hazard-relevant fields from the decode and execute stages plus the data-memory handshake, and drives per-stage register enables, flushes and bubbles. It implements:

- load-use stalls
- branch/JAL redirect flushes
- multi-cycle memory back-pressure with a timeout
- a drain-then-halt sequence on illegal instructions

---
 rtl/pipe_ctrl_pkg.sv | 21 ++
 rtl/pipe_ctrl_hazard_detect.sv | 25 ++
 rtl/pipe_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pipe_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline sequencing controller.
//   pctrl_state_t : controller FSM state (run / drain / halt)
//   halt_cause_t  : reason reported on cause_o once halted
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StDrain = 2'd1,
    StHalt  = 2'd2
  } pctrl_state_t;

  typedef enum logic [1:0] {
    CauseNone    = 2'd0,
    CauseIllegal = 2'd1,
    CauseMemto   = 2'd2
  } halt_cause_t;

  localparam int unsigned DrainCyclesDefault = 3;
  localparam int unsigned MemTimeoutDefault  = 16;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational load-use comparator.
// Flags when the load in EX writes a register that the ID instruction reads.
//   id_rs1_i/id_rs2_i, id_uses_rs1_i/id_uses_rs2_i : ID source operands
//   ex_valid_i, ex_mem_read_i, ex_rd_i              : EX instruction summary
//   lu_hazard_o                                     : stall request
module hazard_detect (
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_uses_rs1_i,
  input  logic       id_uses_rs2_i,
  input  logic       ex_valid_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_i,
  output logic       lu_hazard_o
);

  logic rs1_match, rs2_match;

  assign rs1_match = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
  assign rs2_match = id_uses_rs2_i && (id_rs2_i == ex_rd_i);

  // x0 is hardwired to zero, so a load targeting it never produces a value to wait for.
  assign lu_hazard_o = ex_valid_i && ex_mem_read_i && (ex_rd_i != 5'd0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32 core.
// Drives per-stage enables/flushes from hazards, redirects, memory back-pressure
// and a drain-then-halt sequence on illegal instructions.
//   Inputs : ID operand/illegal info, EX rd/load/redirect info, MEM handshake
//   Outputs: pc/ifid/idex/exmem enables, ifid/idex/memwb flushes,
//            halted_o, trap_o (HALT entry pulse), cause_o, stall_cnt_o
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT  = MemTimeoutDefault,
  parameter int unsigned DRAIN_CYCLES = DrainCyclesDefault
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        id_uses_rs1_i,
  input  logic        id_uses_rs2_i,
  input  logic        id_illegal_i,
  input  logic        ex_valid_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_mem_read_i,
  input  logic        ex_redirect_i,
  input  logic        mem_req_i,
  input  logic        dmem_ready_i,
  output logic        pc_en_o,
  output logic        ifid_en_o,
  output logic        ifid_flush_o,
  output logic        idex_en_o,
  output logic        idex_flush_o,
  output logic        exmem_en_o,
  output logic        memwb_flush_o,
  output logic        halted_o,
  output logic        trap_o,
  output logic [1:0]  cause_o,
  output logic [31:0] stall_cnt_o
);

  pctrl_state_t state_q, state_d;
  halt_cause_t  cause_q, cause_d;
  logic [31:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0]  drain_cnt_q, drain_cnt_d;
  logic [31:0]  stall_cnt_q, stall_cnt_d;
  logic         trap_q, trap_d;

  logic mem_wait, lu_hazard, timeout_hit, drain_last, id_illegal, enter_halt;

  hazard_detect u_hazard_detect (
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_uses_rs1_i (id_uses_rs1_i),
    .id_uses_rs2_i (id_uses_rs2_i),
    .ex_valid_i    (ex_valid_i),
    .ex_mem_read_i (ex_mem_read_i),
    .ex_rd_i       (ex_rd_i),
    .lu_hazard_o   (lu_hazard)
  );

  assign mem_wait    = mem_req_i && !dmem_ready_i;
  assign timeout_hit = mem_wait && (wait_cnt_q == 32'(MEM_TIMEOUT - 1));
  assign drain_last  = drain_cnt_q == 32'(DRAIN_CYCLES - 1);
  assign id_illegal  = id_valid_i && id_illegal_i;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (mem_wait) begin
          if (timeout_hit) state_d = StHalt;
        end else if (!ex_redirect_i && id_illegal) begin
          // A redirect discards the ID instruction, illegal or not.
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (mem_wait) begin
          if (timeout_hit) state_d = StHalt;
        end else if (drain_last) begin
          state_d = StHalt;
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StRun;
    endcase
  end

  // Stage control outputs
  always_comb begin
    pc_en_o       = 1'b1;
    ifid_en_o     = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_en_o     = 1'b1;
    idex_flush_o  = 1'b0;
    exmem_en_o    = 1'b1;
    memwb_flush_o = 1'b0;
    if (rst_i) begin
      pc_en_o       = 1'b0;
      ifid_en_o     = 1'b0;
      idex_en_o     = 1'b0;
      exmem_en_o    = 1'b0;
      ifid_flush_o  = 1'b1;
      idex_flush_o  = 1'b1;
      memwb_flush_o = 1'b1;
    end else if (state_q == StHalt || mem_wait) begin
      pc_en_o       = 1'b0;
      ifid_en_o     = 1'b0;
      idex_en_o     = 1'b0;
      exmem_en_o    = 1'b0;
      memwb_flush_o = 1'b1;
    end else if (state_q == StDrain) begin
      pc_en_o      = 1'b0;
      ifid_en_o    = 1'b0;
      idex_flush_o = 1'b1;
    end else if (ex_redirect_i) begin
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
    end else if (id_illegal || lu_hazard) begin
      pc_en_o      = 1'b0;
      ifid_en_o    = 1'b0;
      idex_flush_o = 1'b1;
    end
  end

  // Counters, cause and trap pulse
  assign enter_halt = (state_q != StHalt) && (state_d == StHalt);

  always_comb begin
    wait_cnt_d  = (mem_wait && state_q != StHalt) ? wait_cnt_q + 32'd1 : 32'd0;
    drain_cnt_d = 32'd0;
    if (state_q == StDrain) begin
      drain_cnt_d = mem_wait ? drain_cnt_q : drain_cnt_q + 32'd1;
    end
    cause_d = cause_q;
    if (enter_halt) cause_d = mem_wait ? CauseMemto : CauseIllegal;
    trap_d      = enter_halt;
    stall_cnt_d = stall_cnt_q;
    if (state_q != StHalt && !pc_en_o) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt_q  <= 32'd0;
      drain_cnt_q <= 32'd0;
      cause_q     <= CauseNone;
      trap_q      <= 1'b0;
      stall_cnt_q <= 32'd0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      cause_q     <= cause_d;
      trap_q      <= trap_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign halted_o    = state_q == StHalt;
  assign trap_o      = trap_q;
  assign cause_o     = cause_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  localparam int unsigned MemTo  = 16;
  localparam int unsigned DrainN = 3;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        id_valid_i = 1'b0;
  logic [4:0]  id_rs1_i = '0, id_rs2_i = '0;
  logic        id_uses_rs1_i = 1'b0, id_uses_rs2_i = 1'b0, id_illegal_i = 1'b0;
  logic        ex_valid_i = 1'b0;
  logic [4:0]  ex_rd_i = '0;
  logic        ex_mem_read_i = 1'b0, ex_redirect_i = 1'b0;
  logic        mem_req_i = 1'b0, dmem_ready_i = 1'b1;
  logic        pc_en_o, ifid_en_o, ifid_flush_o, idex_en_o, idex_flush_o;
  logic        exmem_en_o, memwb_flush_o, halted_o, trap_o;
  logic [1:0]  cause_o;
  logic [31:0] stall_cnt_o;

  pipe_ctrl #(.MEM_TIMEOUT(MemTo), .DRAIN_CYCLES(DrainN)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .id_valid_i    (id_valid_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_uses_rs1_i (id_uses_rs1_i),
    .id_uses_rs2_i (id_uses_rs2_i),
    .id_illegal_i  (id_illegal_i),
    .ex_valid_i    (ex_valid_i),
    .ex_rd_i       (ex_rd_i),
    .ex_mem_read_i (ex_mem_read_i),
    .ex_redirect_i (ex_redirect_i),
    .mem_req_i     (mem_req_i),
    .dmem_ready_i  (dmem_ready_i),
    .pc_en_o       (pc_en_o),
    .ifid_en_o     (ifid_en_o),
    .ifid_flush_o  (ifid_flush_o),
    .idex_en_o     (idex_en_o),
    .idex_flush_o  (idex_flush_o),
    .exmem_en_o    (exmem_en_o),
    .memwb_flush_o (memwb_flush_o),
    .halted_o      (halted_o),
    .trap_o        (trap_o),
    .cause_o       (cause_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, id_valid, u1, u2, ill, ex_valid, ld, redir, req, rdy;
    logic [4:0]  rs1, rs2, rd;
  } stim_t;

  // en = {pc, ifid, idex, exmem}, fl = {ifid, idex, memwb}
  typedef struct {
    logic [3:0]  en;
    logic [2:0]  fl;
    logic        halted, trap, chk_flush;
    logic [1:0]  cause;
    logic [31:0] stall;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   cyc = 0;

  // Reference model: abstract view of the controller
  bit          m_halted;
  int          m_drain_left;   // drain cycles still owed; 0 when not draining
  int          m_waits;        // consecutive memory-wait cycles so far
  bit          m_trap_next;
  logic [1:0]  m_cause;
  logic [31:0] m_stall;

  function automatic stim_t nop();
    stim_t s;
    s = '{rst: 1'b0, id_valid: 1'b0, u1: 1'b0, u2: 1'b0, ill: 1'b0, ex_valid: 1'b0,
          ld: 1'b0, redir: 1'b0, req: 1'b0, rdy: 1'b1, rs1: 5'd0, rs2: 5'd0, rd: 5'd0};
    return s;
  endfunction

  function automatic stim_t rnd(int ill_den, int req_den);
    stim_t s;
    s.rst      = 1'b0;
    s.id_valid = $urandom_range(0, 3) != 0;
    s.ill      = $urandom_range(0, ill_den - 1) == 0;
    s.rs1      = 5'($urandom_range(0, 3));
    s.rs2      = 5'($urandom_range(0, 3));
    s.u1       = $urandom_range(0, 1) == 1;
    s.u2       = $urandom_range(0, 1) == 1;
    s.ex_valid = $urandom_range(0, 3) != 0;
    s.rd       = 5'($urandom_range(0, 3));
    s.ld       = $urandom_range(0, 1) == 1;
    s.redir    = $urandom_range(0, 5) == 0;
    s.req      = $urandom_range(0, req_den - 1) == 0;
    s.rdy      = $urandom_range(0, 1) == 1;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    bit   waiting, lu;
    @(negedge clk);
    cyc++;
    rst_i = s.rst; id_valid_i = s.id_valid; id_rs1_i = s.rs1; id_rs2_i = s.rs2;
    id_uses_rs1_i = s.u1; id_uses_rs2_i = s.u2; id_illegal_i = s.ill;
    ex_valid_i = s.ex_valid; ex_rd_i = s.rd; ex_mem_read_i = s.ld; ex_redirect_i = s.redir;
    mem_req_i = s.req; dmem_ready_i = s.rdy;
    if (s.rst) begin
      e.en = 4'b0000; e.fl = 3'b111; e.halted = 1'b0; e.trap = 1'b0; e.cause = 2'd0;
      e.stall = 32'd0; e.chk_flush = 1'b1;
      m_halted = 0; m_drain_left = 0; m_waits = 0; m_trap_next = 0; m_cause = 2'd0;
      m_stall = 32'd0;
    end else begin
      e.halted = m_halted; e.trap = m_trap_next; e.cause = m_cause; e.stall = m_stall;
      e.chk_flush = 1'b1;
      m_trap_next = 0;
      waiting = s.req && !s.rdy;
      lu = s.ex_valid && s.ld && s.rd != 5'd0 &&
           ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
      if (m_halted || waiting) begin
        e.en = 4'b0000; e.fl = 3'b001; e.chk_flush = 1'b0;
        if (!m_halted) begin
          m_stall++;
          m_waits++;
          if (m_waits == MemTo) begin m_halted = 1; m_cause = 2'd2; m_trap_next = 1; end
        end
      end else begin
        m_waits = 0;
        if (m_drain_left > 0) begin
          e.en = 4'b0011; e.fl = 3'b010; m_stall++;
          m_drain_left--;
          if (m_drain_left == 0) begin m_halted = 1; m_cause = 2'd1; m_trap_next = 1; end
        end else if (s.redir) begin
          e.en = 4'b1111; e.fl = 3'b110;
        end else if (s.id_valid && s.ill) begin
          e.en = 4'b0011; e.fl = 3'b010; m_stall++; m_drain_left = DrainN;
        end else if (lu) begin
          e.en = 4'b0011; e.fl = 3'b010; m_stall++;
        end else begin
          e.en = 4'b1111; e.fl = 3'b000;
        end
      end
    end
    sb_q.push_back(e);
  endtask

  // Monitor: samples each cycle's outputs 2 units after the driving edge
  initial begin
    exp_t e;
    logic [3:0] g_en;
    logic [2:0] g_fl, fmask;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        g_en = {pc_en_o, ifid_en_o, idex_en_o, exmem_en_o};
        g_fl = {ifid_flush_o, idex_flush_o, memwb_flush_o};
        fmask = e.chk_flush ? 3'b111 : 3'b001;
        n_vec++;
        if (g_en !== e.en || (g_fl & fmask) !== (e.fl & fmask) || halted_o !== e.halted ||
            trap_o !== e.trap || cause_o !== e.cause || stall_cnt_o !== e.stall) begin
          n_miss++;
          $display("FAIL cycle%0d: got en=%b fl=%b halt=%b trap=%b cause=%0d stall=%0d ; exp en=%b fl=%b(mask %b) halt=%b trap=%b cause=%0d stall=%0d",
                   cyc, g_en, g_fl, halted_o, trap_o, cause_o, stall_cnt_o,
                   e.en, e.fl, fmask, e.halted, e.trap, e.cause, e.stall);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s, r;
    r = nop(); r.rst = 1'b1;

    // Load-use, then the dependent instruction issues
    apply(r); apply(nop());
    s = nop(); s.ex_valid = 1; s.ld = 1; s.rd = 5'd5; s.id_valid = 1; s.u1 = 1; s.rs1 = 5'd5;
    apply(s); apply(nop()); apply(nop());
    // x0 destination: no stall
    s.rd = 5'd0; s.rs1 = 5'd0; apply(s);
    // Load-use coincident with redirect: flush only
    s.rd = 5'd5; s.rs1 = 5'd5; s.redir = 1; apply(s); apply(nop());

    // Illegal drain then long halt
    s = nop(); s.id_valid = 1; s.ill = 1; apply(s);
    for (int i = 0; i < 24; i++) apply(rnd(4, 3));
    apply(r);   // reset in HALT clears cause

    // Two memory waits inside drain
    s = nop(); s.id_valid = 1; s.ill = 1; apply(s);
    apply(nop());
    s = nop(); s.req = 1; s.rdy = 0; apply(s); apply(s);
    for (int i = 0; i < 5; i++) apply(nop());

    // Timeout after 16 waits
    apply(r);
    s = nop(); s.req = 1; s.rdy = 0;
    for (int i = 0; i < 16; i++) apply(s);
    apply(nop()); apply(nop());
    // 15 waits then ready: counter clears, no halt
    apply(r);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 15; i++) apply(s);
      s.rdy = 1; apply(s); s.rdy = 0;
    end
    apply(nop());

    // Asynchronous reset mid-drain
    s = nop(); s.id_valid = 1; s.ill = 1; apply(s);
    apply(nop());
    #3;
    rst_i = 1'b1;
    #1;
    n_vec++;
    if (halted_o !== 1'b0 || {ifid_flush_o, idex_flush_o, memwb_flush_o} !== 3'b111 ||
        pc_en_o !== 1'b0) begin
      n_miss++;
      $display("FAIL async_rst: got halt=%b fl=%b pc_en=%b ; exp halt=0 fl=111 pc_en=0",
               halted_o, {ifid_flush_o, idex_flush_o, memwb_flush_o}, pc_en_o);
    end
    apply(r); apply(nop()); apply(nop());

    // Randomized segments
    for (int seg = 0; seg < 25; seg++) begin
      apply(r);
      for (int i = 0; i < 60; i++) apply(rnd(30, (seg % 5 == 4) ? 1 : 4));
    end
    apply(nop());

    @(negedge clk);
    #3;
    n_vec++;
    if (sb_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain_queue: got %0d pending, exp 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
